lab7_soc_mem_arbiter: RTL and testbench

LAB7_SOC_MEM_ARBITER -- requirements
Module: lab7_soc_mem_arbiter

---
 rtl/lab7_soc_mem_arb_pkg.sv | 14 +
 rtl/lab7_soc_mem_arbiter_if.sv | 55 +++++
 rtl/lab7_soc_rr_arb2.sv | 27 ++
 rtl/lab7_soc_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_lab7_soc_mem_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lab7_soc_mem_arb_pkg.sv
// rtl/lab7_soc_mem_arb_pkg.sv - shared defaults and FSM state type for the two-master RAM arbiter
package lab7_soc_mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 11;
    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 1200;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/lab7_soc_mem_arbiter_if.sv
// rtl/lab7_soc_mem_arbiter_if.sv - requester (m0/m1) and RAM-side bus bundle for the arbiter
interface lab7_soc_mem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    // slave: the arbiter's view
    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_chipselect, mem_write, mem_writedata,
        output mem_byteenable, mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_chipselect, mem_write, mem_writedata,
        input  mem_byteenable, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/lab7_soc_rr_arb2.sv
// rtl/lab7_soc_rr_arb2.sv - two-way round-robin grant with last-granted pointer
module lab7_soc_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;   // 1 when m1 was granted most recently

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (advance && (req != 2'b00)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/lab7_soc_mem_arbiter.sv
// rtl/lab7_soc_mem_arbiter.sv - round-robin arbiter sharing one single-port RAM between m0/m1; LAB7_SOC_MEM_ARB_BOUNDS_CHECK_EN adds oob_err
module lab7_soc_mem_arbiter
    import lab7_soc_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    lab7_soc_mem_arbiter_if.slave bus
`ifdef LAB7_SOC_MEM_ARB_BOUNDS_CHECK_EN
    ,
    output logic oob_err
`endif
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    logic              grant_q;     // 1 = m1 owns the current transfer
    logic [1:0]        req, arb_grant;
    logic              advance;
    logic              rd_zero_q;   // out-of-range read: return zero instead of RAM data
    logic [DATA_W-1:0] rdata0_q, rdata1_q, rd_value;

    logic [ADDR_W-1:0] sel_address;
    logic              sel_read, sel_write, sel_active, addr_oob;
    logic [DATA_W-1:0] sel_writedata;
    logic [BE_W-1:0]   sel_byteenable;

    assign req = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};

    lab7_soc_rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (advance),
        .grant   (arb_grant)
    );

    // ACCESS uses the granted master's live inputs, not a registered copy
    always_comb begin
        sel_address    = grant_q ? bus.m1_address    : bus.m0_address;
        sel_read       = grant_q ? bus.m1_read       : bus.m0_read;
        sel_write      = grant_q ? bus.m1_write      : bus.m0_write;
        sel_writedata  = grant_q ? bus.m1_writedata  : bus.m0_writedata;
        sel_byteenable = grant_q ? bus.m1_byteenable : bus.m0_byteenable;
    end

    assign sel_active = sel_read | sel_write;

`ifdef LAB7_SOC_MEM_ARB_BOUNDS_CHECK_EN
    logic oob_err_q;

    assign addr_oob = (32'(sel_address) >= 32'(DEPTH));
    assign oob_err  = oob_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_err_q <= 1'b0;
        end else if ((state_q == ACCESS) && sel_active && addr_oob) begin
            oob_err_q <= 1'b1;
        end
    end
`else
    assign addr_oob = 1'b0;
`endif

    assign rd_value = rd_zero_q ? '0 : bus.mem_readdata;

    always_comb begin
        state_d                = state_q;
        advance                = 1'b0;
        bus.mem_address        = '0;
        bus.mem_chipselect     = 1'b0;
        bus.mem_write          = 1'b0;
        bus.mem_writedata      = '0;
        bus.mem_byteenable     = '0;
        bus.m0_waitrequest     = 1'b1;
        bus.m1_waitrequest     = 1'b1;
        bus.m0_readdatavalid   = 1'b0;
        bus.m1_readdatavalid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    advance = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (sel_active) begin
                    bus.mem_address    = sel_address;
                    bus.mem_chipselect = ~addr_oob;
                    bus.mem_write      = sel_write & ~addr_oob;
                    bus.mem_writedata  = sel_writedata;
                    bus.mem_byteenable = sel_byteenable;
                    if (grant_q) bus.m1_waitrequest = 1'b0;
                    else         bus.m0_waitrequest = 1'b0;
                    // a write wins over a simultaneous read
                    state_d = sel_write ? IDLE : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (grant_q) bus.m1_readdatavalid = 1'b1;
                else         bus.m0_readdatavalid = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_clken   = reset_n;
    assign bus.m0_readdata = ((state_q == RESP) && !grant_q) ? rd_value : rdata0_q;
    assign bus.m1_readdata = ((state_q == RESP) &&  grant_q) ? rd_value : rdata1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rd_zero_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q <= state_d;
            if (advance) grant_q <= arb_grant[1];
            if (state_q == ACCESS) rd_zero_q <= addr_oob;
            if (state_q == RESP) begin
                if (grant_q) rdata1_q <= rd_value;
                else         rdata0_q <= rd_value;
            end
        end
    end

endmodule

// File: tb/tb_lab7_soc_mem_arbiter.sv
// tb/tb_lab7_soc_mem_arbiter.sv - directed vector bench for lab7_soc_mem_arbiter with a behavioural RAM
module tb_lab7_soc_mem_arbiter;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    lab7_soc_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

`ifdef LAB7_SOC_MEM_ARB_BOUNDS_CHECK_EN
    logic oob_err;
`endif

    lab7_soc_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .DEPTH(1200)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef LAB7_SOC_MEM_ARB_BOUNDS_CHECK_EN
        ,
        .oob_err (oob_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:2047];

    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_byteenable[b]) ram[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
                end
            end
            bus.mem_readdata <= ram[bus.mem_address];
        end
    end

    typedef struct {
        string       name;
        bit          master;
        bit          wr;
        bit          rd;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic get_wait(input bit m);
        return m ? bus.m1_waitrequest : bus.m0_waitrequest;
    endfunction

    function automatic logic get_rdv(input bit m);
        return m ? bus.m1_readdatavalid : bus.m0_readdatavalid;
    endfunction

    function automatic logic [31:0] get_rdata(input bit m);
        return m ? bus.m1_readdata : bus.m0_readdata;
    endfunction

    task automatic drive_idle();
        bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_address = '0; bus.m0_writedata = '0; bus.m0_byteenable = '0;
        bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_address = '0; bus.m1_writedata = '0; bus.m1_byteenable = '0;
    endtask

    task automatic drive(input bit m, input bit rd, input bit wr, input logic [10:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (m) begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_writedata = d; bus.m1_byteenable = be;
        end else begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_writedata = d; bus.m0_byteenable = be;
        end
    endtask

    // cycle 1 IDLE, cycle 2 ACCESS, cycle 3 RESP (reads), cycle 4 idle
    task automatic run_vec(input vec_t v);
        bit rd_only;
        rd_only = v.rd && !v.wr;
        @(negedge clk);
        drive(v.master, v.rd, v.wr, v.addr, v.wdata, v.be);
        #1 check({v.name, ":c1_wait"}, 32'(get_wait(v.master)), 32'd1);
        @(negedge clk); #1;
        check({v.name, ":c2_wait"},       32'(get_wait(v.master)),  32'd0);
        check({v.name, ":c2_other_wait"}, 32'(get_wait(!v.master)), 32'd1);
        check({v.name, ":c2_cs"},         32'(bus.mem_chipselect),  32'd1);
        check({v.name, ":c2_mem_write"},  32'(bus.mem_write),       32'(v.wr));
        check({v.name, ":c2_addr"},       32'(bus.mem_address),     32'(v.addr));
        check({v.name, ":c2_be"},         32'(bus.mem_byteenable),  32'(v.be));
        if (v.wr) check({v.name, ":c2_wdata"}, bus.mem_writedata, v.wdata);
        @(negedge clk);
        drive_idle();
        #1 check({v.name, ":c3_rdv"}, 32'(get_rdv(v.master)), 32'(rd_only));
        check({v.name, ":c3_wait"}, 32'(get_wait(v.master)), 32'd1);
        if (rd_only) check({v.name, ":c3_rdata"}, get_rdata(v.master), v.exp_rdata);
        @(negedge clk); #1;
        check({v.name, ":c4_rdv"}, 32'(get_rdv(v.master)), 32'd0);
        if (rd_only) check({v.name, ":c4_hold"}, get_rdata(v.master), v.exp_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":m0_wait"},  32'(bus.m0_waitrequest),   32'd1);
        check({tag, ":m1_wait"},  32'(bus.m1_waitrequest),   32'd1);
        check({tag, ":m0_rdv"},   32'(bus.m0_readdatavalid), 32'd0);
        check({tag, ":m1_rdv"},   32'(bus.m1_readdatavalid), 32'd0);
        check({tag, ":m0_rdata"}, bus.m0_readdata,           32'd0);
        check({tag, ":m1_rdata"}, bus.m1_readdata,           32'd0);
        check({tag, ":cs"},       32'(bus.mem_chipselect),   32'd0);
        check({tag, ":mem_wr"},   32'(bus.mem_write),        32'd0);
        check({tag, ":clken"},    32'(bus.mem_clken),        32'd0);
        check({tag, ":addr"},     32'(bus.mem_address),      32'd0);
        check({tag, ":wdata"},    bus.mem_writedata,         32'd0);
        check({tag, ":be"},       32'(bus.mem_byteenable),   32'd0);
    endtask

    vec_t vecs[$];
    vec_t v;
    logic [3:0] exp_bits;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
        bus.mem_readdata = 32'h0;
        drive_idle();
        reset_n = 1'b0;

        vecs.push_back('{"wr_m0_deadbeef", 1'b0, 1'b1, 1'b0, 11'h010, 32'hDEADBEEF, 4'hF, 32'h0});
        vecs.push_back('{"rd_m1_deadbeef", 1'b1, 1'b0, 1'b1, 11'h010, 32'h0,        4'hF, 32'hDEADBEEF});
        vecs.push_back('{"wr_m1_11223344", 1'b1, 1'b1, 1'b0, 11'h020, 32'h11223344, 4'hF, 32'h0});
        vecs.push_back('{"wr_m0_be0010",   1'b0, 1'b1, 1'b0, 11'h020, 32'h0000AB00, 4'b0010, 32'h0});
        vecs.push_back('{"rd_m0_merge",    1'b0, 1'b0, 1'b1, 11'h020, 32'h0,        4'hF, 32'h1122AB44});
        vecs.push_back('{"wr_m1_cafef00d", 1'b1, 1'b1, 1'b0, 11'h021, 32'hCAFEF00D, 4'hF, 32'h0});
        vecs.push_back('{"wr_m0_be0000",   1'b0, 1'b1, 1'b0, 11'h021, 32'hFFFFFFFF, 4'h0, 32'h0});
        vecs.push_back('{"rd_m1_be0_keep", 1'b1, 1'b0, 1'b1, 11'h021, 32'h0,        4'hF, 32'hCAFEF00D});
        vecs.push_back('{"rdwr_m0_wronly", 1'b0, 1'b1, 1'b1, 11'h030, 32'h12345678, 4'hF, 32'h0});
        vecs.push_back('{"rd_m1_after_rw", 1'b1, 1'b0, 1'b1, 11'h030, 32'h0,        4'hF, 32'h12345678});
        vecs.push_back('{"wr_m1_top_be9",  1'b1, 1'b1, 1'b0, 11'd1199, 32'hAABBCCDD, 4'b1001, 32'h0});
        vecs.push_back('{"rd_m0_top",      1'b0, 1'b0, 1'b1, 11'd1199, 32'h0,       4'hF, 32'hAA0000DD});

        // reset values
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("reset_release:clken", 32'(bus.mem_clken), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // both masters reading continuously from reset: m0,m1,m0,m1
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 11'h010, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 11'h020, 32'h0, 4'hF);
        for (int c = 1; c <= 12; c++) begin
            #1;
            exp_bits = {(c % 6) != 2, (c % 6) != 5, (c % 6) == 3, (c % 6) == 0};
            check($sformatf("rr_c%0d:{w0,w1,v0,v1}", c),
                  32'({bus.m0_waitrequest, bus.m1_waitrequest, bus.m0_readdatavalid, bus.m1_readdatavalid}),
                  32'(exp_bits));
            if (exp_bits[1]) check($sformatf("rr_c%0d:m0_rdata", c), bus.m0_readdata, 32'hDEADBEEF);
            if (exp_bits[0]) check($sformatf("rr_c%0d:m1_rdata", c), bus.m1_readdata, 32'h1122AB44);
            @(negedge clk);
        end
        drive_idle();
        @(negedge clk);

        // reset during RESP of an m1 read aborts the response
        drive(1'b1, 1'b1, 1'b0, 11'h010, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        drive_idle();
        #1 check_reset_outputs("rst_in_resp");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("rst_in_resp_after%0d:m1_rdv", c), 32'(bus.m1_readdatavalid), 32'd0);
            @(negedge clk);
        end

        // request withdrawn before ACCESS: no strobe, no write
        drive(1'b0, 1'b0, 1'b1, 11'h040, 32'h5555AAAA, 4'hF);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        #1 check("drop:cs", 32'(bus.mem_chipselect), 32'd0);
        check("drop:mem_write", 32'(bus.mem_write), 32'd0);
        @(negedge clk);
        #1 check("drop:next_idle_wait", 32'(bus.m0_waitrequest), 32'd1);
        v = '{"rd_m0_after_drop", 1'b0, 1'b0, 1'b1, 11'h040, 32'h0, 4'hF, 32'h0};
        run_vec(v);

`ifdef LAB7_SOC_MEM_ARB_BOUNDS_CHECK_EN
        v = '{"rd_m0_prime", 1'b0, 1'b0, 1'b1, 11'h010, 32'h0, 4'hF, 32'hDEADBEEF};
        run_vec(v);
        check("oob:initial", 32'(oob_err), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 11'd1200, 32'h0, 4'hF);
        @(negedge clk);
        #1 check("oob:c2_cs", 32'(bus.mem_chipselect), 32'd0);
        check("oob:c2_wait", 32'(bus.m0_waitrequest), 32'd0);
        @(negedge clk);
        drive_idle();
        #1 check("oob:c3_rdv", 32'(bus.m0_readdatavalid), 32'd1);
        check("oob:c3_rdata", bus.m0_readdata, 32'd0);
        check("oob:c3_err", 32'(oob_err), 32'd1);
        @(negedge clk);
        v = '{"rd_m1_after_oob", 1'b1, 1'b0, 1'b1, 11'h020, 32'h0, 4'hF, 32'h1122AB44};
        run_vec(v);
        check("oob:sticky", 32'(oob_err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
